gshare_predictor: RTL and testbench

Parametrised branch direction predictor: a table of 2^INDEX_W saturating counters indexed by the fetch PC XORed with a global branch history register (gshare; bimodal when HIST_W = 0). It sits beside fetch and answers one lookup per cycle with a registered prediction. It accepts one resolved-branch update per cycle from execute, and keeps saturating lookup and mispredict statistics for performance monitoring.

---
 rtl/gshare_predictor_pkg.sv | 30 +++
 rtl/gshare_predictor_sat_counter.sv | 47 ++++
 rtl/gshare_predictor.sv | 142 ++++++++++++++
 tb/tb_gshare_predictor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared helpers for the gshare predictor: counter reset value, saturating
// arithmetic and the PC/history index hash, all on 32-bit carriers.
package predictor_pkg;

    localparam int unsigned MAX_W = 32;

    // Weakly not-taken: one below the taken threshold.
    function automatic logic [MAX_W-1:0] ctr_init(input int unsigned w);
        return (32'h1 << (w - 1)) - 32'h1;
    endfunction

    function automatic logic [MAX_W-1:0] ctr_max(input int unsigned w);
        return (w >= MAX_W) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                                 input int unsigned w);
        return (v == ctr_max(w)) ? v : v + 32'h1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_dec(input logic [MAX_W-1:0] v);
        return (v == '0) ? v : v - 32'h1;
    endfunction

    function automatic logic [MAX_W-1:0] index_hash(input logic [MAX_W-1:0] pc_field,
                                                    input logic [MAX_W-1:0] hist);
        return pc_field ^ hist;
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter.sv
// Generic W-bit saturating up/down counter with asynchronous reset to INIT_VAL.
module sat_counter
    import predictor_pkg::*;
#(
    parameter int unsigned W        = 2,
    parameter int unsigned INIT_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [MAX_W-1:0] INIT_WIDE = INIT_VAL;

    logic [W-1:0]     cnt_q;
    logic [W-1:0]     cnt_d;
    logic [MAX_W-1:0] cnt_wide;
    logic [MAX_W-1:0] nxt_wide;
    logic             unused_nxt_bits;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        cnt_wide = MAX_W'(cnt_q);
        nxt_wide = cnt_wide;
        if (inc && !dec) begin
            nxt_wide = sat_inc(cnt_wide, W);
        end else if (dec && !inc) begin
            nxt_wide = sat_dec(cnt_wide);
        end
        cnt_d = nxt_wide[W-1:0];
    end

    assign unused_nxt_bits = ^nxt_wide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= INIT_WIDE[W-1:0];
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: PC xor global history indexes a table of
// saturating counters; one registered lookup and one resolved update per cycle.
module gshare_predictor
    import predictor_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned HIST_W  = 6,
    parameter int unsigned STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [PC_W-1:0]    req_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    input  logic               upd_pred_taken,
    output logic [STAT_W-1:0]  stat_lookups,
    output logic [STAT_W-1:0]  stat_mispredicts
);

    localparam int unsigned DEPTH = 1 << INDEX_W;

    logic [CTR_W-1:0]   ctr_val [DEPTH];
    logic [INDEX_W-1:0] hist_ext;
    logic [MAX_W-1:0]   hash_wide;
    logic [INDEX_W-1:0] lookup_index;
    logic [CTR_W-1:0]   lookup_ctr;

    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [INDEX_W-1:0] pred_index_q, pred_index_d;
    logic               unused_bits;

    // History only advances at resolve, so wrong-path lookups never pollute it.
    generate
        if (HIST_W > 0) begin : g_hist
            logic [HIST_W-1:0] ghr_q;
            logic [HIST_W-1:0] ghr_d;
            logic [HIST_W:0]   ghr_shifted;

            always_comb begin
                ghr_shifted = {ghr_q, upd_taken};
                ghr_d       = ghr_q;
                if (upd_valid) begin
                    ghr_d = ghr_shifted[HIST_W-1:0];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr_q <= '0;
                end else begin
                    ghr_q <= ghr_d;
                end
            end

            assign hist_ext = INDEX_W'(ghr_q);
        end else begin : g_no_hist
            assign hist_ext = '0;
        end
    endgenerate

    // Counter table; reads below see pre-edge values, giving read-before-write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            logic upd_hit;
            assign upd_hit = upd_valid && (upd_index == INDEX_W'(gi));

            sat_counter #(
                .W        (CTR_W),
                .INIT_VAL (ctr_init(CTR_W))
            ) u_ctr (
                .clk   (clk),
                .rst   (rst),
                .inc   (upd_hit && upd_taken),
                .dec   (upd_hit && !upd_taken),
                .count (ctr_val[gi])
            );
        end
    endgenerate

    always_comb begin
        hash_wide    = index_hash(MAX_W'(req_pc[INDEX_W+1:2]), MAX_W'(hist_ext));
        lookup_index = hash_wide[INDEX_W-1:0];
        lookup_ctr   = ctr_val[lookup_index];

        pred_valid_d = req_valid;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (req_valid) begin
            pred_taken_d = lookup_ctr[CTR_W-1];
            pred_index_d = lookup_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_index = pred_index_q;

    sat_counter #(
        .W        (STAT_W),
        .INIT_VAL (0)
    ) u_stat_lookups (
        .clk   (clk),
        .rst   (rst),
        .inc   (req_valid),
        .dec   (1'b0),
        .count (stat_lookups)
    );

    sat_counter #(
        .W        (STAT_W),
        .INIT_VAL (0)
    ) u_stat_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .inc   (upd_valid && (upd_taken != upd_pred_taken)),
        .dec   (1'b0),
        .count (stat_mispredicts)
    );

    assign unused_bits = ^{req_pc[PC_W-1:INDEX_W+2], req_pc[1:0], hash_wide, lookup_ctr};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: a bimodal instance (HIST_W=0, STAT_W=4) and a gshare instance
// (HIST_W=6) share stimulus; expected values are hand-computed per step.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0;

    logic        a_pred_valid, a_pred_taken;
    logic [5:0]  a_pred_index;
    logic [3:0]  a_stat_lookups, a_stat_mispredicts;
    logic        b_pred_valid, b_pred_taken;
    logic [5:0]  b_pred_index;
    logic [15:0] b_stat_lookups, b_stat_mispredicts;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.PC_W(32), .INDEX_W(6), .CTR_W(2), .HIST_W(0), .STAT_W(4)) u_bimodal (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(a_pred_valid), .pred_taken(a_pred_taken), .pred_index(a_pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .stat_lookups(a_stat_lookups), .stat_mispredicts(a_stat_mispredicts)
    );

    gshare_predictor #(.PC_W(32), .INDEX_W(6), .CTR_W(2), .HIST_W(6), .STAT_W(16)) u_gshare (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_index(b_pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .stat_lookups(b_stat_lookups), .stat_mispredicts(b_stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("t=%0t check %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
    endtask

    // Drive one cycle of stimulus, pass the edge, sample 1ns later, then idle inputs.
    task automatic cyc(input logic rv, input logic [31:0] pc, input logic uv,
                       input logic [5:0] idx, input logic tk, input logic ptk);
        req_valid      = rv;
        req_pc         = pc;
        upd_valid      = uv;
        upd_index      = idx;
        upd_taken      = tk;
        upd_pred_taken = ptk;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [5:0] idx, input logic tk);
        cyc(1'b0, 32'h0, 1'b1, idx, tk, 1'b0);
    endtask

    logic [31:0] tp_pcs [8];

    initial begin
        tp_pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h14};

        // Reset state
        @(posedge clk);
        #1;
        check("rst_pred_valid", 32'(a_pred_valid), 32'd0);
        check("rst_pred_taken", 32'(a_pred_taken), 32'd0);
        check("rst_pred_index", 32'(a_pred_index), 32'd0);
        check("rst_stat_lookups", 32'(a_stat_lookups), 32'd0);
        rst = 1'b0;

        // Saturation on index 5 (bimodal)
        lookup(32'h14);
        check("first_lookup_nt", 32'(a_pred_taken), 32'd0);
        check("first_lookup_idx", 32'(a_pred_index), 32'd5);
        check("first_lookup_valid", 32'(a_pred_valid), 32'd1);
        for (int i = 0; i < 3; i++) update(6'd5, 1'b1);
        lookup(32'h14);
        check("sat_3taken", 32'(a_pred_taken), 32'd1);
        update(6'd5, 1'b1);
        lookup(32'h14);
        check("sat_4taken", 32'(a_pred_taken), 32'd1);
        update(6'd5, 1'b0);
        lookup(32'h14);
        check("sat_top_held_ctr2", 32'(a_pred_taken), 32'd1);
        update(6'd5, 1'b0);
        lookup(32'h14);
        check("sat_ctr1_nt", 32'(a_pred_taken), 32'd0);
        for (int i = 0; i < 3; i++) update(6'd5, 1'b0);
        update(6'd5, 1'b1);
        lookup(32'h14);
        check("sat_bottom_held_ctr1", 32'(a_pred_taken), 32'd0);
        update(6'd5, 1'b1);
        lookup(32'h14);
        check("sat_ctr2_taken", 32'(a_pred_taken), 32'd1);

        // Collision: counter back to 1, then same-cycle lookup and taken update
        update(6'd5, 1'b0);
        cyc(1'b1, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
        check("collision_old_value", 32'(a_pred_taken), 32'd0);
        lookup(32'h14);
        check("collision_next_cycle", 32'(a_pred_taken), 32'd1);

        // Throughput: 8 back-to-back lookups, index 5 (taken) last
        for (int i = 0; i < 8; i++) begin
            lookup(tp_pcs[i]);
            check("tp_valid", 32'(a_pred_valid), 32'd1);
            check("tp_index", 32'(a_pred_index), tp_pcs[i] >> 2);
            check("tp_taken", 32'(a_pred_taken), (tp_pcs[i] == 32'h14) ? 32'd1 : 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        check("idle_valid", 32'(a_pred_valid), 32'd0);
        check("idle_taken_held", 32'(a_pred_taken), 32'd1);
        check("idle_index_held", 32'(a_pred_index), 32'd5);

        // Asynchronous reset mid-stream after training entry 5 to 3
        update(6'd5, 1'b1);
        lookup(32'h14);
        check("pre_rst_taken", 32'(a_pred_taken), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(a_pred_valid), 32'd0);
        check("async_rst_taken", 32'(a_pred_taken), 32'd0);
        check("async_rst_index", 32'(a_pred_index), 32'd0);
        check("async_rst_lookups", 32'(a_stat_lookups), 32'd0);
        check("async_rst_mispred", 32'(a_stat_mispredicts), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lookup(32'h14);
        check("post_rst_nt", 32'(a_pred_taken), 32'd0);
        check("post_rst_lookups", 32'(a_stat_lookups), 32'd1);

        // Hash: history T,T,NT -> 0b110
        update(6'd0, 1'b1);
        update(6'd0, 1'b1);
        update(6'd0, 1'b0);
        lookup(32'h00);
        check("hash_pc0_idx", 32'(b_pred_index), 32'd6);
        check("bimodal_pc0_idx", 32'(a_pred_index), 32'd0);
        lookup(32'h18);
        check("hash_pc18_idx", 32'(b_pred_index), 32'd0);
        check("bimodal_pc18_idx", 32'(a_pred_index), 32'd6);
        cyc(1'b1, 32'h00, 1'b1, 6'd0, 1'b1, 1'b0);
        check("hash_preshift_idx", 32'(b_pred_index), 32'd6);
        lookup(32'h00);
        check("hash_postshift_idx", 32'(b_pred_index), 32'd13);
        check("mix_lookups", 32'(a_stat_lookups), 32'd5);
        check("mix_mispred", 32'(a_stat_mispredicts), 32'd3);

        // Statistics saturation (STAT_W = 4)
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h28, 1'b1, 6'd10, 1'b1, 1'b0);
        check("stat_lookups_3", 32'(a_stat_lookups), 32'd3);
        check("stat_mispred_3", 32'(a_stat_mispredicts), 32'd3);
        cyc(1'b0, 32'h0, 1'b1, 6'd10, 1'b1, 1'b1);
        check("stat_matched_no_inc", 32'(a_stat_mispredicts), 32'd3);
        check("stat_noreq_no_inc", 32'(a_stat_lookups), 32'd3);
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'h28, 1'b1, 6'd10, 1'b0, 1'b1);
        check("stat_lookups_sat", 32'(a_stat_lookups), 32'd15);
        check("stat_mispred_sat", 32'(a_stat_mispredicts), 32'd15);
        check("stat_lookups_wide", 32'(b_stat_lookups), 32'd23);
        cyc(1'b1, 32'h28, 1'b1, 6'd10, 1'b1, 1'b0);
        check("stat_lookups_hold", 32'(a_stat_lookups), 32'd15);
        check("stat_mispred_hold", 32'(a_stat_mispredicts), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
